// File: rtl/gpio_pkg6.sv
// Shared definitions for the GPIO input-capture slice.
//   GPIO_DATA_WIDTH / DEBOUNCE_W : default widths used by the modules' parameters
//   gpio_vec_t                   : one bit per GPIO line
//   int_type_e                   : per-bit interrupt type (level or edge)
//   gpio_event                   : per-bit event function driven by the filtered pin
package gpio_pkg6;

    localparam int GPIO_DATA_WIDTH = 16;
    localparam int DEBOUNCE_W      = 4;

    typedef logic [GPIO_DATA_WIDTH-1:0] gpio_vec_t;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } int_type_e;

    // pol = 1 selects rising edge / high level, pol = 0 selects falling edge / low level.
    function automatic logic gpio_event(input int_type_e kind, input logic pol,
                                        input logic filt, input logic filt_d);
        logic ev;
        ev = 1'b0;
        case (kind)
            EDGE:    ev = pol ? (filt & ~filt_d) : (~filt & filt_d);
            default: ev = pol ? filt : ~filt;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/gpio_debounce6.sv
// Single-bit input conditioner: synchroniser chain followed by a debounce filter.
//   pclk6, n_p_reset6 : clock and asynchronous active-low reset
//   pin_in            : raw asynchronous pad input
//   debounce_cnt      : number of consecutive differing cycles needed to commit (0 = bypass)
//   filt              : registered, debounced pin value
module gpio_debounce6 #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 4
) (
    input  logic                  pclk6,
    input  logic                  n_p_reset6,
    input  logic                  pin_in,
    input  logic [DEBOUNCE_W-1:0] debounce_cnt,
    output logic                  filt
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_bit;
    logic [DEBOUNCE_W-1:0]  cnt_reg, cnt_next;
    logic                   filt_reg, filt_next;

    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_in};
        end
    end

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    // cnt_reg counts earlier consecutive mismatching cycles; the current mismatch
    // commits once it is the debounce_cnt-th. Using >= rather than == means a
    // threshold lowered below the running count commits on the next mismatch.
    always_comb begin
        cnt_next  = cnt_reg;
        filt_next = filt_reg;
        if (debounce_cnt == '0) begin
            filt_next = sync_bit;
            cnt_next  = '0;
        end else if (sync_bit == filt_reg) begin
            cnt_next  = '0;
        end else if (cnt_reg >= (debounce_cnt - DEBOUNCE_W'(1))) begin
            filt_next = sync_bit;
            cnt_next  = '0;
        end else if (cnt_reg != '1) begin
            cnt_next  = cnt_reg + DEBOUNCE_W'(1);
        end
    end

    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            filt_reg <= filt_next;
        end
    end

    assign filt = filt_reg;

endmodule

// File: rtl/gpio_input_capture6.sv
// GPIO input capture and interrupt stage.
//   pclk6, n_p_reset6 : clock and asynchronous active-low reset
//   gpio_pin_in6      : raw pad inputs
//   n_gpio_pin_oe6    : active-low output enable; a driven pin raises no events
//   debounce_cnt6     : debounce threshold (0 = bypass)
//   int_type6/pol6    : per-bit event selection (edge/level, rising-high/falling-low)
//   int_mask6         : per-bit enable onto irq6 (does not gate status capture)
//   int_clr6          : write-1-to-clear strobe for int_status6
//   gpio_data_in6     : debounced pin values
//   int_status6       : sticky raw interrupt status
//   irq6              : OR of masked status
module gpio_input_capture6 #(
    parameter int GPIO_DATA_WIDTH = gpio_pkg6::GPIO_DATA_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_W      = gpio_pkg6::DEBOUNCE_W
) (
    input  logic                       pclk6,
    input  logic                       n_p_reset6,
    input  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in6,
    input  logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe6,
    input  logic [DEBOUNCE_W-1:0]      debounce_cnt6,
    input  logic [GPIO_DATA_WIDTH-1:0] int_type6,
    input  logic [GPIO_DATA_WIDTH-1:0] int_pol6,
    input  logic [GPIO_DATA_WIDTH-1:0] int_mask6,
    input  logic [GPIO_DATA_WIDTH-1:0] int_clr6,
    output logic [GPIO_DATA_WIDTH-1:0] gpio_data_in6,
    output logic [GPIO_DATA_WIDTH-1:0] int_status6,
    output logic                       irq6
);

    import gpio_pkg6::*;

    logic [GPIO_DATA_WIDTH-1:0] filt_vec;
    logic [GPIO_DATA_WIDTH-1:0] filt_d_reg;
    logic [GPIO_DATA_WIDTH-1:0] event_vec;
    logic [GPIO_DATA_WIDTH-1:0] status_reg, status_next;

    for (genvar gi = 0; gi < GPIO_DATA_WIDTH; gi++) begin : g_bit
        logic ev_bit;

        gpio_debounce6 #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_debounce (
            .pclk6        (pclk6),
            .n_p_reset6   (n_p_reset6),
            .pin_in       (gpio_pin_in6[gi]),
            .debounce_cnt (debounce_cnt6),
            .filt         (filt_vec[gi])
        );

        // A pin we are driving ourselves must not interrupt us.
        always_comb begin
            ev_bit = 1'b0;
            if (n_gpio_pin_oe6[gi]) begin
                ev_bit = gpio_event(int_type_e'(int_type6[gi]), int_pol6[gi],
                                    filt_vec[gi], filt_d_reg[gi]);
            end
        end

        assign event_vec[gi] = ev_bit;
    end

    // A new event takes priority over a clear landing in the same cycle.
    always_comb begin
        status_next = event_vec | (status_reg & ~int_clr6);
    end

    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            filt_d_reg <= '0;
            status_reg <= '0;
        end else begin
            filt_d_reg <= filt_vec;
            status_reg <= status_next;
        end
    end

    assign gpio_data_in6 = filt_vec;
    assign int_status6   = status_reg;
    assign irq6          = |(status_reg & int_mask6);

endmodule

// File: tb/tb_gpio_input_capture6.sv
module tb_gpio_input_capture6;

    localparam int W  = 16;
    localparam int S  = 2;
    localparam int DW = 4;

    logic          pclk6 = 1'b0;
    logic          n_p_reset6 = 1'b0;
    logic [W-1:0]  gpio_pin_in6, n_gpio_pin_oe6, int_type6, int_pol6, int_mask6, int_clr6;
    logic [DW-1:0] debounce_cnt6;
    logic [W-1:0]  gpio_data_in6, int_status6;
    logic          irq6;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 pclk6 = ~pclk6;

    gpio_input_capture6 #(
        .GPIO_DATA_WIDTH (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_W      (DW)
    ) dut (
        .pclk6          (pclk6),
        .n_p_reset6     (n_p_reset6),
        .gpio_pin_in6   (gpio_pin_in6),
        .n_gpio_pin_oe6 (n_gpio_pin_oe6),
        .debounce_cnt6  (debounce_cnt6),
        .int_type6      (int_type6),
        .int_pol6       (int_pol6),
        .int_mask6      (int_mask6),
        .int_clr6       (int_clr6),
        .gpio_data_in6  (gpio_data_in6),
        .int_status6    (int_status6),
        .irq6           (irq6)
    );

    // Reference model: the synchroniser is a pure S-cycle delay line of sampled
    // pins; debouncing is "commit once the pin has differed for N cycles in a row".
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_filt, m_filt_d, m_status;
    int           m_run[W];

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < S; k++) m_q.push_back('0);
        m_filt   = '0;
        m_filt_d = '0;
        m_status = '0;
        for (int k = 0; k < W; k++) m_run[k] = 0;
    endtask

    task automatic model_update();
        logic [W-1:0] sync_now, nf, rise, fall, ev;
        sync_now = m_q[0];
        nf = m_filt;
        for (int k = 0; k < W; k++) begin
            if (debounce_cnt6 == 0) begin
                nf[k] = sync_now[k];
                m_run[k] = 0;
            end else if (sync_now[k] != m_filt[k]) begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] >= int'(debounce_cnt6)) begin
                    nf[k] = sync_now[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        rise = m_filt & ~m_filt_d;
        fall = ~m_filt & m_filt_d;
        ev = (int_type6 & int_pol6 & rise) | (int_type6 & ~int_pol6 & fall) |
             (~int_type6 & int_pol6 & m_filt) | (~int_type6 & ~int_pol6 & ~m_filt);
        ev = ev & n_gpio_pin_oe6;
        m_status = ev | (m_status & ~int_clr6);
        m_filt_d = m_filt;
        m_filt   = nf;
        m_q.push_back(gpio_pin_in6);
        void'(m_q.pop_front());
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // One clock: advance the model on the pre-edge inputs, then compare after the edge.
    task automatic step();
        if (!n_p_reset6) model_reset();
        else model_update();
        @(posedge pclk6);
        #1;
        cyc++;
        check("data", gpio_data_in6, m_filt);
        check("status", int_status6, m_status);
        check("irq", {15'b0, irq6}, {15'b0, |(m_status & int_mask6)});
    endtask

    typedef struct {
        logic [W-1:0] pin;
        logic [W-1:0] clr;
        logic [W-1:0] exp_data;
        logic [W-1:0] exp_status;
        logic         exp_irq;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Bypass debounce, bit3 rising edge: data after 3 edges, status after 4.
        tbl[0] = '{16'h0008, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{16'h0008, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[2] = '{16'h0008, 16'h0000, 16'h0008, 16'h0000, 1'b0};
        tbl[3] = '{16'h0008, 16'h0000, 16'h0008, 16'h0008, 1'b1};
        tbl[4] = '{16'h0008, 16'h0000, 16'h0008, 16'h0008, 1'b1};
        tbl[5] = '{16'h0008, 16'h0008, 16'h0008, 16'h0000, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 16'h0008, 16'h0000, 1'b0};
        tbl[7] = '{16'h0000, 16'h0000, 16'h0008, 16'h0000, 1'b0};
        tbl[8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};

        gpio_pin_in6   = '0;
        n_gpio_pin_oe6 = 16'hFFFF;
        int_type6      = 16'hFFFF;
        int_pol6       = 16'hFFFF;
        int_mask6      = '0;
        int_clr6       = '0;
        debounce_cnt6  = '0;
        model_reset();

        // Reset held while pins toggle.
        for (int k = 0; k < 6; k++) begin
            gpio_pin_in6 = 16'($urandom);
            step();
            check("rst_data", gpio_data_in6, '0);
            check("rst_status", int_status6, '0);
        end
        gpio_pin_in6 = '0;
        n_p_reset6 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("idle_data", gpio_data_in6, '0);
        end

        // Table-driven rising-edge / clear sequence.
        int_mask6 = 16'h0008;
        for (int i = 0; i < 10; i++) begin
            gpio_pin_in6 = tbl[i].pin;
            int_clr6     = tbl[i].clr;
            step();
            check("tbl_data", gpio_data_in6, tbl[i].exp_data);
            check("tbl_status", int_status6, tbl[i].exp_status);
            check("tbl_irq", {15'b0, irq6}, {15'b0, tbl[i].exp_irq});
        end
        int_clr6 = '0;

        // Debounce 4: 3-cycle glitch rejected, a held level commits after 2+4 edges.
        int_mask6 = '0;
        debounce_cnt6 = 4'd4;
        for (int k = 0; k < 11; k++) begin
            gpio_pin_in6[0] = (k < 3);
            step();
            check("deb_glitch", {15'b0, gpio_data_in6[0]}, 16'h0);
        end
        gpio_pin_in6[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("deb_commit", {15'b0, gpio_data_in6[0]}, {15'b0, k >= 6});
            check("deb_status", {15'b0, int_status6[0]}, {15'b0, k >= 7});
        end

        // Level-low on bit5: set wins over a simultaneous clear.
        debounce_cnt6 = '0;
        int_type6[5] = 1'b0;
        int_pol6[5]  = 1'b0;
        step();
        check("lvl_set", {15'b0, int_status6[5]}, 16'h1);
        int_clr6 = 16'h0020;
        step();
        int_clr6 = '0;
        check("lvl_setwins", {15'b0, int_status6[5]}, 16'h1);
        gpio_pin_in6[5] = 1'b1;
        repeat (4) step();
        int_clr6 = 16'h0020;
        step();
        int_clr6 = '0;
        check("lvl_cleared", {15'b0, int_status6[5]}, 16'h0);
        step();
        check("lvl_stays0", {15'b0, int_status6[5]}, 16'h0);

        // Driven pin: data tracks, no status.
        n_gpio_pin_oe6[7] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            gpio_pin_in6[7] = ((k / 4) % 2) == 1;
            step();
            check("oe_status", {15'b0, int_status6[7]}, 16'h0);
        end

        // Masked pending bit, then unmask raises irq6 without a clock edge.
        gpio_pin_in6[9] = 1'b1;
        repeat (5) step();
        check("mask_status", {15'b0, int_status6[9]}, 16'h1);
        check("mask_irq0", {15'b0, irq6}, 16'h0);
        int_mask6 = 16'h0200;
        #1;
        check("unmask_irq", {15'b0, irq6}, 16'h1);
        step();

        // Randomised traffic with occasional configuration changes.
        for (int k = 0; k < 600; k++) begin
            if (k % 64 == 0) begin
                debounce_cnt6  = 4'($urandom_range(0, 5));
                int_type6      = 16'($urandom);
                int_pol6       = 16'($urandom);
                int_mask6      = 16'($urandom);
                n_gpio_pin_oe6 = ~(16'($urandom) & 16'($urandom));
            end
            gpio_pin_in6 = gpio_pin_in6 ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            int_clr6     = 16'($urandom) & 16'($urandom);
            step();
        end
        int_clr6 = '0;

        // Asynchronous reset in the middle of a debounce count.
        debounce_cnt6 = 4'd4;
        gpio_pin_in6 = ~gpio_pin_in6;
        repeat (3) step();
        n_p_reset6 = 1'b0;
        #1;
        check("arst_data", gpio_data_in6, '0);
        check("arst_status", int_status6, '0);
        check("arst_irq", {15'b0, irq6}, 16'h0);
        repeat (2) step();
        n_p_reset6 = 1'b1;
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
